fetch_inst_queue: RTL and testbench

Parametrised decoupling queue between instruction fetch and the decoders, the successor to the fixed two-slot ID capture/skid logic. Accepts aligned fetch packets of FETCH_W instructions, keeps only the slots named by the packet's start offset and end index, and stores them in order in a DEPTH-entry circular buffer. Presents up to ISSUE_W oldest instructions per cycle, each with its own PC. Supports partial consumption by the consumer, backpressure, and a single-cycle redirect flush.

---
 rtl/fiq_pkg.sv | 34 +++
 rtl/fiq_compact.sv | 44 ++++
 rtl/fetch_inst_queue.sv | 121 ++++++++++++
 tb/tb_fetch_inst_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fiq_pkg.sv
// ============================================================================
//  Module      : fiq_pkg
//  Description : Shared widths, entry layout and slot-PC helper for the
//                fetch instruction queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fiq_pkg;

    // Entry layout: {pc, inst}, PC in the upper half
    localparam int FIQ_PC_WD    = 32;
    localparam int FIQ_INST_WD  = 32;
    localparam int FIQ_ENTRY_WD = FIQ_PC_WD + FIQ_INST_WD;

    // Default geometry
    localparam int FIQ_FETCH_W  = 2;
    localparam int FIQ_ISSUE_W  = 2;
    localparam int FIQ_DEPTH    = 8;

    // PC of slot 'slot' inside the aligned fetch block containing base_pc
    function automatic logic [31:0] fiq_slot_pc(
        input logic [31:0] base_pc,
        input int          slot,
        input int          fetch_w
    );
        logic [31:0] block_mask;
        block_mask = ~((fetch_w << 2) - 1);
        return (base_pc & block_mask) | (slot << 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fiq_compact.sv
// ============================================================================
//  Module      : fiq_compact
//  Description : Left-justifies the kept slots (start..end) of a fetch packet
//                into {pc, inst} entries and reports how many were kept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fiq_compact
    import fiq_pkg::*;
#(
    parameter int FETCH_W = FIQ_FETCH_W,
    parameter int SLOT_WD = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
    parameter int CNT_WD  = $clog2(FETCH_W + 1)
) (
    input  logic [31:0]                     fetch_pc,
    input  logic [FETCH_W*32-1:0]           fetch_data,
    input  logic [SLOT_WD-1:0]              start_slot,
    input  logic [SLOT_WD-1:0]              end_slot,
    output logic [FETCH_W*FIQ_ENTRY_WD-1:0] entries,
    output logic [CNT_WD-1:0]               n
);

    // Output entry j carries packet slot start+j; entries past n are don't-care
    for (genvar j = 0; j < FETCH_W; j++) begin : g_slot
        logic [SLOT_WD:0]   w_slot;
        logic [SLOT_WD-1:0] w_sel;
        assign w_slot = {1'b0, start_slot} + (SLOT_WD+1)'(j);
        assign w_sel  = w_slot[SLOT_WD-1:0];
        assign entries[j*FIQ_ENTRY_WD +: FIQ_ENTRY_WD] =
            {fiq_slot_pc(fetch_pc, 32'(w_slot), FETCH_W), fetch_data[w_sel*32 +: 32]};
    end

    // Kept-slot count; an end index before the start slot means an empty packet
    always_comb begin
        n = '0;
        if (end_slot >= start_slot) begin
            n = CNT_WD'({1'b0, end_slot} - {1'b0, start_slot} + 1'b1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_inst_queue.sv
// ============================================================================
//  Module      : fetch_inst_queue
//  Description : Circular decoupling queue between fetch and decode. Stores
//                the kept slots of each fetch packet in order and presents up
//                to ISSUE_W oldest instructions with their PCs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_inst_queue
    import fiq_pkg::*;
#(
    parameter int FETCH_W = FIQ_FETCH_W,
    parameter int ISSUE_W = FIQ_ISSUE_W,
    parameter int DEPTH   = FIQ_DEPTH
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic                                         flush,
    input  logic                                         fetch_valid,
    input  logic [31:0]                                  fetch_pc,
    input  logic [FETCH_W*32-1:0]                        fetch_data,
    input  logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] fetch_end,
    output logic                                         fetch_ready,
    output logic [ISSUE_W-1:0]                           issue_valid,
    output logic [ISSUE_W*32-1:0]                        issue_pc,
    output logic [ISSUE_W*32-1:0]                        issue_inst,
    input  logic [$clog2(ISSUE_W+1)-1:0]                 issue_accept,
    output logic [$clog2(DEPTH+1)-1:0]                   occupancy
);

    localparam int c_slot_wd = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int c_n_wd    = $clog2(FETCH_W + 1);
    localparam int c_ptr_wd  = $clog2(DEPTH);
    localparam int c_cnt_wd  = $clog2(DEPTH + 1);

    logic [FIQ_ENTRY_WD-1:0]         r_mem [DEPTH];
    logic [c_ptr_wd-1:0]             r_head;
    logic [c_ptr_wd-1:0]             r_tail;
    logic [c_cnt_wd-1:0]             r_count;

    logic [c_slot_wd-1:0]            w_start;
    logic [FETCH_W*FIQ_ENTRY_WD-1:0] w_entries;
    logic [c_n_wd-1:0]               w_n;
    logic                            w_enq_fire;
    logic [c_cnt_wd-1:0]             w_n_enq;
    logic [c_cnt_wd-1:0]             w_avail;
    logic [c_cnt_wd-1:0]             w_accept;
    logic [c_cnt_wd-1:0]             w_n_deq;

    if (FETCH_W > 1) begin : g_start_multi
        assign w_start = fetch_pc[c_slot_wd+1:2];
    end else begin : g_start_single
        assign w_start = '0;
    end

    fiq_compact #(
        .FETCH_W (FETCH_W),
        .SLOT_WD (c_slot_wd),
        .CNT_WD  (c_n_wd)
    ) u_compact (
        .fetch_pc   (fetch_pc),
        .fetch_data (fetch_data),
        .start_slot (w_start),
        .end_slot   (fetch_end),
        .entries    (w_entries),
        .n          (w_n)
    );

    // Ready only from the registered count: a same-cycle dequeue earns no credit
    assign fetch_ready = (r_count <= c_cnt_wd'(DEPTH - FETCH_W));
    assign w_enq_fire  = fetch_valid & fetch_ready & ~flush;
    assign w_n_enq     = w_enq_fire ? c_cnt_wd'(w_n) : '0;

    // Consumer over-acceptance is clamped to what is actually presented
    assign w_avail  = (r_count < c_cnt_wd'(ISSUE_W)) ? r_count : c_cnt_wd'(ISSUE_W);
    assign w_accept = c_cnt_wd'(issue_accept);
    assign w_n_deq  = (w_accept < w_avail) ? w_accept : w_avail;

    // Issue window: the oldest ISSUE_W entries, valid as a contiguous prefix
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_issue
        logic [c_ptr_wd-1:0] w_rd_idx;
        assign w_rd_idx                = r_head + c_ptr_wd'(i);
        assign issue_valid[i]          = (r_count > c_cnt_wd'(i));
        assign issue_pc[i*32 +: 32]    = r_mem[w_rd_idx][FIQ_ENTRY_WD-1 -: FIQ_PC_WD];
        assign issue_inst[i*32 +: 32]  = r_mem[w_rd_idx][FIQ_INST_WD-1:0];
    end

    assign occupancy = r_count;

    // Storage write: compacted entry j lands at tail+j, wrapping naturally
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (c_n_wd'(j) < w_n) begin
                    r_mem[r_tail + c_ptr_wd'(j)] <= w_entries[j*FIQ_ENTRY_WD +: FIQ_ENTRY_WD];
                end
            end
        end
    end

    // Pointers and count; reset beats flush, flush discards this cycle's traffic
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_ptr_wd'(w_n_deq);
            r_tail  <= r_tail + c_ptr_wd'(w_n_enq);
            r_count <= r_count + w_n_enq - w_n_deq;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_inst_queue.sv
// ============================================================================
//  Module      : tb_fetch_inst_queue
//  Description : Scoreboard bench for fetch_inst_queue (FETCH_W=2, ISSUE_W=2,
//                DEPTH=8) with directed packets and hand-computed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_inst_queue;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_data;
    logic        fetch_end;
    logic        fetch_ready;
    logic [1:0]  issue_valid;
    logic [63:0] issue_pc;
    logic [63:0] issue_inst;
    logic [1:0]  issue_accept;
    logic [3:0]  occupancy;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t exp_q[$];
    int   checks;
    int   errors;

    fetch_inst_queue #(
        .FETCH_W (2),
        .ISSUE_W (2),
        .DEPTH   (8)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_data   (fetch_data),
        .fetch_end    (fetch_end),
        .fetch_ready  (fetch_ready),
        .issue_valid  (issue_valid),
        .issue_pc     (issue_pc),
        .issue_inst   (issue_inst),
        .issue_accept (issue_accept),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus; expected entries join the scoreboard at the edge
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] d0,
                       input logic [31:0] d1, input logic fe, input logic [1:0] acc,
                       input logic fl);
        ent_t        pend[$];
        logic [31:0] words [2];
        bit          fire;
        int          s;
        fetch_valid  = fv;
        fetch_pc     = pc;
        fetch_data   = {d1, d0};
        fetch_end    = fe;
        issue_accept = acc;
        flush        = fl;
        words[0]     = d0;
        words[1]     = d1;
        s            = int'(pc[2]);
        fire         = fv && !fl && ((8 - exp_q.size()) >= 2);
        if (fire) begin
            for (int k = s; k <= int'(fe); k++) begin
                ent_t e;
                e.pc   = {pc[31:3], k[0], 2'b00};
                e.inst = words[k];
                pend.push_back(e);
            end
        end
        @(posedge clk);
        if (fl) exp_q.delete();
        else foreach (pend[i]) exp_q.push_back(pend[i]);
        #1;
    endtask

    // Monitor: compare presented slots against the scoreboard, retire accepted ones
    always @(negedge clk) begin
        int         nv;
        logic [1:0] want;
        if (resetn) begin
            nv   = 0;
            want = (exp_q.size() >= 2) ? 2'b11 : (exp_q.size() == 1) ? 2'b01 : 2'b00;
            chk("mon_issue_valid", 32'(issue_valid), 32'(want));
            chk("mon_occupancy", 32'(occupancy), 32'(exp_q.size()));
            for (int i = 0; i < 2; i++) begin
                if (issue_valid[i] === 1'b1) begin
                    nv++;
                    if (i < exp_q.size()) begin
                        chk($sformatf("mon_slot%0d_pc", i), issue_pc[i*32 +: 32], exp_q[i].pc);
                        chk($sformatf("mon_slot%0d_inst", i), issue_inst[i*32 +: 32], exp_q[i].inst);
                    end
                end
            end
            checks++;
            if (int'(issue_accept) > nv) begin
                errors++;
                $display("FAIL accept_protocol: actual=%0d required<=%0d", issue_accept, nv);
            end
            if (!flush) begin
                for (int i = 0; i < int'(issue_accept) && i < nv; i++) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        resetn       = 1'b0;
        flush        = 1'b0;
        fetch_valid  = 1'b0;
        fetch_pc     = '0;
        fetch_data   = '0;
        fetch_end    = 1'b0;
        issue_accept = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);

        // Aligned full packet
        cyc(1'b1, 32'hBFC0_0000, 32'h1111_1111, 32'h2222_2222, 1'b1, 2'd0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'd2);
        chk("full_valid", 32'(issue_valid), 32'd3);
        chk("full_pc0", issue_pc[31:0], 32'hBFC0_0000);
        chk("full_pc1", issue_pc[63:32], 32'hBFC0_0004);
        chk("full_inst1", issue_inst[63:32], 32'h2222_2222);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("drain1_occ", 32'(occupancy), 32'd0);

        // Unaligned start: only slot 1 kept
        cyc(1'b1, 32'hBFC0_000C, 32'h3333_3333, 32'h4444_4444, 1'b1, 2'd0, 1'b0);
        chk("unal_occ", 32'(occupancy), 32'd1);
        chk("unal_valid", 32'(issue_valid), 32'd1);
        chk("unal_pc0", issue_pc[31:0], 32'hBFC0_000C);
        chk("unal_inst0", issue_inst[31:0], 32'h4444_4444);

        // Predicted cut after slot 0, then an empty packet
        cyc(1'b1, 32'h8000_0000, 32'h5555_5555, 32'h6666_6666, 1'b0, 2'd0, 1'b0);
        chk("cut_occ", 32'(occupancy), 32'd2);
        chk("cut_pc1", issue_pc[63:32], 32'h8000_0000);
        chk("cut_inst1", issue_inst[63:32], 32'h5555_5555);
        cyc(1'b1, 32'h8000_0004, 32'h7777_7777, 32'h8888_8888, 1'b0, 2'd0, 1'b0);
        chk("empty_pkt_occ", 32'(occupancy), 32'd2);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("drain2_occ", 32'(occupancy), 32'd0);

        // Backpressure to full, then single-step drain across the wrap
        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 32'h0000_1000 + 32'(p*8), 32'hD000_0000 + 32'(p*2),
                32'hD000_0001 + 32'(p*2), 1'b1, 2'd0, 1'b0);
        end
        chk("bp_full_occ", 32'(occupancy), 32'd8);
        chk("bp_full_ready", 32'(fetch_ready), 32'd0);
        cyc(1'b1, 32'h0000_1020, 32'hE000_0000, 32'hE000_0001, 1'b1, 2'd0, 1'b0);
        chk("bp_drop_occ", 32'(occupancy), 32'd8);
        cyc(1'b1, 32'h0000_1020, 32'hE000_0000, 32'hE000_0001, 1'b1, 2'd1, 1'b0);
        chk("bp7_occ", 32'(occupancy), 32'd7);
        chk("bp7_ready", 32'(fetch_ready), 32'd0);
        cyc(1'b1, 32'h0000_1020, 32'hE000_0000, 32'hE000_0001, 1'b1, 2'd1, 1'b0);
        chk("bp6_occ", 32'(occupancy), 32'd6);
        chk("bp6_ready", 32'(fetch_ready), 32'd1);
        chk("bp6_pc0", issue_pc[31:0], 32'h0000_1008);
        cyc(1'b1, 32'h0000_1020, 32'hE000_0000, 32'hE000_0001, 1'b1, 2'd1, 1'b0);
        chk("bp_refill_occ", 32'(occupancy), 32'd7);
        repeat (3) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("wrap_last_pc0", issue_pc[31:0], 32'h0000_1024);
        chk("wrap_last_inst0", issue_inst[31:0], 32'hE000_0001);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b0);
        chk("drain3_occ", 32'(occupancy), 32'd0);

        // Partial consume with simultaneous enqueue
        cyc(1'b1, 32'h0000_2000, 32'hC0DE_0000, 32'hC0DE_0001, 1'b1, 2'd0, 1'b0);
        cyc(1'b1, 32'h0000_2008, 32'hC0DE_0002, 32'hC0DE_0003, 1'b0, 2'd0, 1'b0);
        chk("pc3_occ", 32'(occupancy), 32'd3);
        cyc(1'b1, 32'h0000_2010, 32'hC0DE_0004, 32'hC0DE_0005, 1'b1, 2'd1, 1'b0);
        chk("pc_enq_deq_occ", 32'(occupancy), 32'd4);
        chk("pc_enq_deq_pc0", issue_pc[31:0], 32'h0000_2004);
        chk("pc_enq_deq_pc1", issue_pc[63:32], 32'h0000_2008);

        // Flush with traffic on both sides, then recovery
        cyc(1'b1, 32'h0000_2018, 32'hC0DE_0006, 32'hC0DE_0007, 1'b0, 2'd0, 1'b0);
        chk("pre_flush_occ", 32'(occupancy), 32'd5);
        cyc(1'b1, 32'h0000_3000, 32'hF000_0000, 32'hF000_0001, 1'b1, 2'd2, 1'b1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(issue_valid), 32'd0);
        chk("flush_ready", 32'(fetch_ready), 32'd1);
        cyc(1'b1, 32'h0000_4000, 32'hAAAA_0000, 32'hAAAA_0001, 1'b1, 2'd0, 1'b0);
        chk("post_flush_valid", 32'(issue_valid), 32'd3);
        chk("post_flush_pc0", issue_pc[31:0], 32'h0000_4000);
        chk("post_flush_occ", 32'(occupancy), 32'd2);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        chk("final_occ", 32'(occupancy), 32'd0);

        cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
